// File: rtl/err_watchdog_pkg.sv
// Shared state encoding, error cause codes and a width helper for err_watchdog.
package err_watchdog_pkg;

    typedef enum logic [1:0] {
        WD_INIT   = 2'd0,
        WD_RUN    = 2'd1,
        WD_HALTED = 2'd2,
        WD_ERR    = 2'd3
    } wd_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_ERRIN = 2'd1,
        CAUSE_HANG  = 2'd2,
        CAUSE_LIMIT = 2'd3
    } wd_cause_e;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/wd_sat_counter.sv
// Saturating up-counter with synchronous clear (priority over enable) and async reset.
module wd_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/err_watchdog.sv
// Error/hang watchdog feeding the clock/reset generator's sticky err input.
// Define ERR_WATCHDOG_CYCLE_LIMIT_EN to add the global cycle-limit error (cause 3).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WD_INIT   | post-reset settling, STARTUP cycles, all inputs ignored
// WD_RUN    | monitoring err_in, halt and commit activity
// WD_HALTED | core halted, idle_cnt frozen, only err_in (or limit) matters
// WD_ERR    | err asserted, first cause latched, left only by rst
module err_watchdog
    import err_watchdog_pkg::*;
#(
    parameter int TIMEOUT_W  = 16,
    parameter int TIMEOUT    = 1000,
    parameter int STARTUP    = 2,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit,
    input  logic                 halt,
    input  logic                 err_in,
    output logic                 err,
    output logic [1:0]           err_cause,
    output logic [1:0]           wd_state,
    output logic [TIMEOUT_W-1:0] idle_cnt
);

    localparam int SU_W = cnt_width(STARTUP);
    localparam logic [SU_W-1:0] SU_LAST = (STARTUP > 1) ? SU_W'(STARTUP - 1) : '0;
    localparam logic [TIMEOUT_W-1:0] IDLE_LAST = TIMEOUT_W'(TIMEOUT - 1);

    wd_state_e       state_q, state_d;
    wd_cause_e       cause_q, cause_d;
    logic            err_q, err_d;
    logic [SU_W-1:0] su_cnt_q, su_cnt_d;
    logic            su_done;
    logic            idle_clr, idle_en;
    logic            glob_en;
    logic            limit_hit;

    wd_sat_counter #(.W(TIMEOUT_W)) u_idle (
        .clk (clk),
        .rst (rst),
        .clr (idle_clr),
        .en  (idle_en),
        .cnt (idle_cnt)
    );

`ifdef ERR_WATCHDOG_CYCLE_LIMIT_EN
    logic [31:0] glob_cnt;

    wd_sat_counter #(.W(32)) u_glob (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (glob_en),
        .cnt (glob_cnt)
    );

    // Compare the pre-increment value so the error lands on the MAX_CYCLES-th counted edge.
    assign limit_hit = glob_en && (glob_cnt == 32'(MAX_CYCLES - 1));
`else
    assign limit_hit = 1'b0;
`endif

    // STARTUP of 0 or 1 both leave INIT on the first clock.
    assign su_done = (STARTUP <= 1) || (su_cnt_q == SU_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WD_INIT;
            cause_q  <= CAUSE_NONE;
            err_q    <= 1'b0;
            su_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            err_q    <= err_d;
            su_cnt_q <= su_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        su_cnt_d = su_cnt_q;
        idle_clr = 1'b0;
        idle_en  = 1'b0;
        glob_en  = 1'b0;

        unique case (state_q)
            WD_INIT: begin
                idle_clr = 1'b1;
                if (su_done) begin
                    state_d = WD_RUN;
                end else begin
                    su_cnt_d = su_cnt_q + SU_W'(1);
                end
            end
            WD_RUN: begin
                glob_en = 1'b1;
                if (err_in) begin
                    state_d = WD_ERR;
                    cause_d = CAUSE_ERRIN;
                end else if (halt) begin
                    state_d  = WD_HALTED;
                    idle_clr = commit;
                end else if (commit) begin
                    idle_clr = 1'b1;
                end else begin
                    idle_en = 1'b1;
                    if (idle_cnt == IDLE_LAST) begin
                        state_d = WD_ERR;
                        cause_d = CAUSE_HANG;
                    end
                end
                // The limit edge occurs once, so it must override a same-cycle halt.
                if ((state_d != WD_ERR) && limit_hit) begin
                    state_d = WD_ERR;
                    cause_d = CAUSE_LIMIT;
                end
            end
            WD_HALTED: begin
                glob_en = 1'b1;
                if (err_in) begin
                    state_d = WD_ERR;
                    cause_d = CAUSE_ERRIN;
                end else if (limit_hit) begin
                    state_d = WD_ERR;
                    cause_d = CAUSE_LIMIT;
                end
            end
            WD_ERR: begin
            end
            default: begin
                state_d = WD_ERR;
            end
        endcase

        err_d = (state_d == WD_ERR);
    end

    assign err       = err_q;
    assign err_cause = cause_q;
    assign wd_state  = state_q;

endmodule

// File: tb/tb_err_watchdog.sv
// Directed plus randomized bench for err_watchdog, checked against a cycle-level behavioural model.
module tb_err_watchdog;

    localparam int TIMEOUT_W = 16;
    localparam int TIMEOUT   = 8;
    localparam int STARTUP   = 2;
    localparam int MAX_CYC   = 50;
    localparam int IDLE_MAX  = (1 << TIMEOUT_W) - 1;
`ifdef ERR_WATCHDOG_CYCLE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
    localparam int KEEP_N   = 45;
`else
    localparam bit LIMIT_EN = 1'b0;
    localparam int KEEP_N   = 100;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 commit, halt, err_in;
    logic                 err;
    logic [1:0]           err_cause;
    logic [1:0]           wd_state;
    logic [TIMEOUT_W-1:0] idle_cnt;

    int tests = 0;
    int fails = 0;

    // Behavioural model: state 0=INIT 1=RUN 2=HALTED 3=ERR
    int m_state, m_idle, m_cause, m_init, m_glob;

    err_watchdog #(
        .TIMEOUT_W  (TIMEOUT_W),
        .TIMEOUT    (TIMEOUT),
        .STARTUP    (STARTUP),
        .MAX_CYCLES (MAX_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .commit    (commit),
        .halt      (halt),
        .err_in    (err_in),
        .err       (err),
        .err_cause (err_cause),
        .wd_state  (wd_state),
        .idle_cnt  (idle_cnt)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_idle = 0; m_cause = 0; m_init = 0; m_glob = 0;
    endtask

    task automatic model_step(input bit c, input bit h, input bit e);
        int nxt;
        bool_limit: begin end
        nxt = m_state;
        case (m_state)
            0: begin
                m_init++;
                if (m_init >= ((STARTUP < 1) ? 1 : STARTUP)) nxt = 1;
            end
            1: begin
                if (e) begin
                    nxt = 3; m_cause = 1;
                end else if (h) begin
                    nxt = 2;
                    if (c) m_idle = 0;
                end else if (c) begin
                    m_idle = 0;
                end else begin
                    if (m_idle + 1 == TIMEOUT) begin
                        nxt = 3; m_cause = 2;
                    end
                    if (m_idle < IDLE_MAX) m_idle++;
                end
                if (LIMIT_EN && nxt != 3 && m_glob + 1 == MAX_CYC) begin
                    nxt = 3; m_cause = 3;
                end
            end
            2: begin
                if (e) begin
                    nxt = 3; m_cause = 1;
                end else if (LIMIT_EN && m_glob + 1 == MAX_CYC) begin
                    nxt = 3; m_cause = 3;
                end
            end
            default: ;
        endcase
        if (m_state == 1 || m_state == 2) m_glob++;
        m_state = nxt;
    endtask

    task automatic cyc(input bit c, input bit h, input bit e);
        commit = c; halt = h; err_in = e;
        @(posedge clk);
        model_step(c, h, e);
        #1;
        chk("wd_state", 32'(wd_state), 32'(m_state));
        chk("err", 32'(err), 32'(m_state == 3));
        chk("err_cause", 32'(err_cause), 32'(m_cause));
        if (m_state != 3) chk("idle_cnt", 32'(idle_cnt), 32'(m_idle));
    endtask

    task automatic do_reset();
        rst = 1'b1; commit = 1'b0; halt = 1'b0; err_in = 1'b0;
        #1;
        chk("rst_err_async", 32'(err), 32'd0);
        chk("rst_state_async", 32'(wd_state), 32'd0);
        chk("rst_cause_async", 32'(err_cause), 32'd0);
        chk("rst_idle_async", 32'(idle_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int peak;
        int pc;
        rst = 1'b1; commit = 1'b0; halt = 1'b0; err_in = 1'b0;
        model_reset();

        // Reset release, then hang with no commits
        #100;
        chk("reset_state", 32'(wd_state), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_idle", 32'(idle_cnt), 32'd0);
        #101;
        rst = 1'b0;
        cyc(0, 0, 0);
        chk("init_hold", 32'(wd_state), 32'd0);
        cyc(0, 0, 0);
        chk("run_entry", 32'(wd_state), 32'd1);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 0, 0);
        chk("hang_not_yet", 32'(err), 32'd0);
        cyc(0, 0, 0);
        chk("hang_err", 32'(err), 32'd1);
        chk("hang_cause", 32'(err_cause), 32'd2);
        chk("hang_state", 32'(wd_state), 32'd3);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0);
        chk("hang_held", 32'(err), 32'd1);

        // Commit every 7th cycle keeps the core alive
        do_reset();
        cyc(0, 0, 0); cyc(0, 0, 0);
        peak = 0;
        for (int i = 1; i <= KEEP_N; i++) begin
            cyc((i % 7) == 0, 0, 0);
            if (int'(idle_cnt) > peak) peak = int'(idle_cnt);
        end
        chk("keep_err", 32'(err), 32'd0);
        chk("keep_peak", 32'(peak), 32'd6);

        // Commits spaced one cycle too far apart trigger the hang
        do_reset();
        cyc(0, 0, 0); cyc(0, 0, 0);
        for (int i = 1; i <= 9; i++) cyc((i % 9) == 0, 0, 0);
        chk("late_commit_err", 32'(err), 32'd1);
        chk("late_commit_cause", 32'(err_cause), 32'd2);

        // err_in beats halt; later timeouts do not change the cause; async reset
        do_reset();
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(0, 1, 1);
        chk("errin_cause", 32'(err_cause), 32'd1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0);
        chk("errin_sticky_cause", 32'(err_cause), 32'd1);
        chk("errin_before_rst", 32'(err), 32'd1);
        do_reset();

        // Halt freezes idle_cnt, commit ignored, err_in still reported
        cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        chk("pre_halt_idle", 32'(idle_cnt), 32'd3);
        cyc(0, 1, 0);
        for (int i = 0; i < 2 * TIMEOUT; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        chk("halt_idle", 32'(idle_cnt), 32'd3);
        chk("halt_state", 32'(wd_state), 32'd2);
        chk("halt_err", 32'(err), 32'd0);
        cyc(0, 0, 1);
        chk("halt_errin", 32'(err), 32'd1);
        chk("halt_errin_cause", 32'(err_cause), 32'd1);

        // Global cycle limit with commit every cycle
        do_reset();
        for (int i = 0; i < (LIMIT_EN ? 60 : 202); i++) cyc(1, 0, 0);
        chk("limit_err", 32'(err), LIMIT_EN ? 32'd1 : 32'd0);
        chk("limit_cause", 32'(err_cause), LIMIT_EN ? 32'd3 : 32'd0);

        // Randomized runs against the model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            pc = int'($urandom_range(2, 12));
            for (int i = 0; i < 80; i++) begin
                cyc($urandom_range(0, pc - 1) == 0,
                    $urandom_range(0, 99) == 0,
                    $urandom_range(0, 149) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
